sysid_checker: RTL and testbench

Boot-time Avalon-MM read master that sits directly upstream of the system-ID slave and consumes its two words. On a start pulse it reads the ID word (address 0) and the timestamp word (address 1), compares both against build-time expected values, and reports pass/fail/timeout to the reset/boot controller. This lets the design refuse to release the Nios core when the FPGA image and the software build disagree.

---
 rtl/sysid_checker_pkg.sv | 17 +
 rtl/sysid_checker_if.sv | 23 ++
 rtl/sysid_checker_wdog.sv | 31 +++
 rtl/sysid_checker.sv | 104 ++++++++++
 tb/tb_sysid_checker.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the boot-time system-ID checker.
package sysid_checker_pkg;

  localparam int CNT_W = 16;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_RD_TS,
    ST_CMP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the system-ID slave.
interface sysid_checker_if;

  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );

endinterface

// File: rtl/sysid_checker_wdog.sv
// Saturating stall counter; tc flags that the next stalled cycle is the last one allowed.
module sysid_checker_wdog
  import sysid_checker_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Compare against N-1 so the FSM leaves on the edge that samples the Nth stall.
  assign tc = (cnt >= TC_VAL);

endmodule

// File: rtl/sysid_checker.sv
// Reads the system-ID and timestamp words once per start and reports pass/fail/timeout.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_RD_ID | reading address 0 (ID word)
// ST_RD_TS | reading address 1 (timestamp word)
// ST_CMP   | comparing captured words against expected values
// ST_DONE  | result valid, waiting for a new start
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1459291431,
  parameter int unsigned TIMEOUT_CYCLES     = 256
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  sysid_checker_if.master        avm,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [31:0]            id_value,
  output logic [31:0]            ts_value
);

  state_t state, state_next;
  logic   tc, in_read, stall, wd_clr;
  logic   read_d, addr_d, done_d, accept, cap_id, cap_ts, timeout_hit;

  assign in_read = (state == ST_RD_ID) || (state == ST_RD_TS);
  assign stall   = in_read && avm.avm_waitrequest;
  assign wd_clr  = (state_next != state) || !in_read;

  sysid_checker_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .clock (clock),
    .reset (reset),
    .clr   (wd_clr),
    .inc   (stall),
    .tc    (tc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_RD_ID;
      ST_RD_ID: if (!avm.avm_waitrequest) state_next = ST_RD_TS;
                else if (tc)              state_next = ST_DONE;
      ST_RD_TS: if (!avm.avm_waitrequest) state_next = ST_CMP;
                else if (tc)              state_next = ST_DONE;
      ST_CMP:   state_next = ST_DONE;
      ST_DONE:  if (start) state_next = ST_RD_ID;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Registered outputs are decoded from next state so they line up with the state register.
  always_comb begin
    read_d      = (state_next == ST_RD_ID) || (state_next == ST_RD_TS);
    addr_d      = (state_next == ST_RD_TS) ? ADDR_TS : ADDR_ID;
    done_d      = (state_next == ST_DONE);
    accept      = start && ((state == ST_IDLE) || (state == ST_DONE));
    cap_id      = (state == ST_RD_ID) && !avm.avm_waitrequest;
    cap_ts      = (state == ST_RD_TS) && !avm.avm_waitrequest;
    timeout_hit = stall && tc;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      avm.avm_read    <= 1'b0;
      avm.avm_address <= ADDR_ID;
      done            <= 1'b0;
      pass            <= 1'b0;
      timeout         <= 1'b0;
      id_value        <= '0;
      ts_value        <= '0;
    end else begin
      avm.avm_read    <= read_d;
      avm.avm_address <= addr_d;
      done            <= done_d;
      if (accept) begin
        pass    <= 1'b0;
        timeout <= 1'b0;
      end else if (state == ST_CMP) begin
        pass <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TIMESTAMP);
      end else if (timeout_hit) begin
        timeout <= 1'b1;
      end
      if (cap_id) id_value <= avm.avm_readdata;
      if (cap_ts) ts_value <= avm.avm_readdata;
    end
  end

  assign busy = (state == ST_RD_ID) || (state == ST_RD_TS) || (state == ST_CMP);

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker against a behavioural system-ID slave.
module tb_sysid_checker;
  import sysid_checker_pkg::*;

  localparam logic [31:0] TS_GOOD = 32'd1459291431;
  localparam logic [31:0] TS_BAD  = 32'd1459291430;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        wr    = 1'b0;
  logic [31:0] mem0  = 32'h0;
  logic [31:0] mem1  = TS_GOOD;
  logic        busy, done, pass, timeout;
  logic [31:0] id_value, ts_value;
  int          checks = 0;
  int          errors = 0;

  sysid_checker_if bus ();

  assign bus.avm_waitrequest = wr;
  assign bus.avm_readdata    = (bus.avm_address == ADDR_TS) ? mem1 : mem0;

  sysid_checker #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .avm      (bus.master),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .timeout  (timeout),
    .id_value (id_value),
    .ts_value (ts_value)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_read", 32'(bus.avm_read), 32'd0);
    chk("rst_addr", 32'(bus.avm_address), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_tmo", 32'(timeout), 32'd0);
    chk("rst_id", id_value, 32'd0);
    chk("rst_ts", ts_value, 32'd0);
    reset = 1'b0;
    tick();
    tick();
    chk("idle_read", 32'(bus.avm_read), 32'd0);

    // Zero-wait, matching words
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_rd_id_read", 32'(bus.avm_read), 32'd1);
    chk("t1_rd_id_addr", 32'(bus.avm_address), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_rd_ts_read", 32'(bus.avm_read), 32'd1);
    chk("t1_rd_ts_addr", 32'(bus.avm_address), 32'd1);
    tick();
    chk("t1_cmp_read", 32'(bus.avm_read), 32'd0);
    chk("t1_cmp_addr", 32'(bus.avm_address), 32'd0);
    chk("t1_cmp_done", 32'(done), 32'd0);
    chk("t1_ts_cap", ts_value, TS_GOOD);
    tick();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_pass", 32'(pass), 32'd1);
    chk("t1_tmo", 32'(timeout), 32'd0);
    chk("t1_busy_done", 32'(busy), 32'd0);

    // Wrong timestamp, restarted from DONE
    mem1 = TS_BAD;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_done_drop", 32'(done), 32'd0);
    chk("t2_pass_clr", 32'(pass), 32'd0);
    tick();
    tick();
    tick();
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_pass", 32'(pass), 32'd0);
    chk("t2_tmo", 32'(timeout), 32'd0);
    chk("t2_ts", ts_value, TS_BAD);

    // Three stall cycles on each read
    mem1 = TS_GOOD;
    wr = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_id_stall_read", 32'(bus.avm_read), 32'd1);
      chk("t3_id_stall_addr", 32'(bus.avm_address), 32'd0);
    end
    wr = 1'b0;
    tick();
    wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_ts_stall_read", 32'(bus.avm_read), 32'd1);
      chk("t3_ts_stall_addr", 32'(bus.avm_address), 32'd1);
    end
    chk("t3_ts_not_yet", ts_value, TS_BAD);
    wr = 1'b0;
    tick();
    chk("t3_cmp_done", 32'(done), 32'd0);
    tick();
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_pass", 32'(pass), 32'd1);
    chk("t3_ts", ts_value, TS_GOOD);

    // start during RD_TS is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_cmp_busy", 32'(busy), 32'd1);
    chk("t4_cmp_read", 32'(bus.avm_read), 32'd0);
    tick();
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_pass", 32'(pass), 32'd1);
    tick();
    chk("t4_done_hold", 32'(done), 32'd1);

    // Timeout on the ID read (TIMEOUT_CYCLES=8)
    mem0 = 32'hDEAD_BEEF;
    wr = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_pass_clr", 32'(pass), 32'd0);
    for (int i = 0; i < 7; i++) tick();
    chk("t5_stall7_read", 32'(bus.avm_read), 32'd1);
    chk("t5_stall7_done", 32'(done), 32'd0);
    tick();
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_tmo", 32'(timeout), 32'd1);
    chk("t5_pass", 32'(pass), 32'd0);
    chk("t5_read_drop", 32'(bus.avm_read), 32'd0);
    chk("t5_id_kept", id_value, 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);

    // Reset in the middle of the ID read
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_read_on", 32'(bus.avm_read), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_read", 32'(bus.avm_read), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_tmo", 32'(timeout), 32'd0);
    chk("t6_rst_id", id_value, 32'd0);
    chk("t6_rst_ts", ts_value, 32'd0);
    tick();
    reset = 1'b0;
    wr = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t6_post_read", 32'(bus.avm_read), 32'd0);
    chk("t6_post_busy", 32'(busy), 32'd0);
    chk("t6_post_done", 32'(done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
